// File: rtl/mlp_layer_sequencer_if.sv
// Bundles the start/done control, memory read ports and result stream of the
// layer sequencer. The sequencer side is "slave"; the surrounding system is "master".
interface mlp_layer_sequencer_if #(
  parameter int INPUTS  = 784,
  parameter int OUTPUTS = 10,
  parameter int DATA_W  = 32
);
  localparam int IN_AW  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int W_AW   = (INPUTS * OUTPUTS > 1) ? $clog2(INPUTS * OUTPUTS) : 1;
  localparam int OUT_AW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

  logic              start;
  logic              busy;
  logic              done;
  logic [IN_AW-1:0]  in_addr;
  logic [DATA_W-1:0] in_data;
  logic [W_AW-1:0]   w_addr;
  logic [DATA_W-1:0] w_data;
  logic [OUT_AW-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              out_valid;
  logic [OUT_AW-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic [OUT_AW-1:0] predicted_class;

  modport master (
    output start, in_data, w_data, b_data,
    input  busy, done, in_addr, w_addr, b_addr,
    input  out_valid, out_index, out_data, predicted_class
  );

  modport slave (
    input  start, in_data, w_data, b_data,
    output busy, done, in_addr, w_addr, b_addr,
    output out_valid, out_index, out_data, predicted_class
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Evaluates one fully-connected layer on a single shared MAC, one neuron at a time,
// streaming each saturated Q7.24 result and tracking the argmax across neurons.
module mlp_layer_sequencer #(
  parameter int INPUTS  = 784,
  parameter int OUTPUTS = 10,
  parameter int DATA_W  = 32,
  parameter int FRAC    = 24,
  parameter int RELU    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mlp_layer_sequencer_if.slave  bus
);
  localparam int IN_AW  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int W_AW   = (INPUTS * OUTPUTS > 1) ? $clog2(INPUTS * OUTPUTS) : 1;
  localparam int OUT_AW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam int ACC_W  = 2 * DATA_W;
  localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(INPUTS - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(OUTPUTS - 1);

  typedef enum logic [2:0] {IDLE, FETCH_BIAS, MAC, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [OUT_AW-1:0]         j_q, j_d;
  logic [IN_AW-1:0]          k_q, k_d;
  logic [IN_AW-1:0]          in_addr_q, in_addr_d;
  logic [W_AW-1:0]           w_addr_q, w_addr_d;
  logic [OUT_AW-1:0]         b_addr_q, b_addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  best_val_q, best_val_d;
  logic [OUT_AW-1:0]         best_idx_q, best_idx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      out_valid_q, out_valid_d;
  logic [OUT_AW-1:0]         out_index_q, out_index_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [OUT_AW-1:0]         pred_q, pred_d;

  logic signed [ACC_W-1:0]   x_ext, w_ext, b_ext, prod_full, prod;
  logic signed [DATA_W-1:0]  r;

  // Full-precision signed product, rescaled back to Q7.24 with a flooring shift.
  always_comb begin
    x_ext     = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
    w_ext     = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
    b_ext     = {{DATA_W{bus.b_data[DATA_W-1]}}, bus.b_data};
    prod_full = x_ext * w_ext;
    prod      = prod_full >>> FRAC;
  end

  // Saturate the wide accumulator to the output word, then optionally apply ReLU.
  always_comb begin
    r = acc_q[DATA_W-1:0];
    if (!acc_q[ACC_W-1] && (|acc_q[ACC_W-2:DATA_W-1])) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc_q[ACC_W-1] && !(&acc_q[ACC_W-2:DATA_W-1])) begin
      r = {1'b1, {(DATA_W-1){1'b0}}};
    end
    if ((RELU != 0) && r[DATA_W-1]) begin
      r = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    k_d         = k_q;
    in_addr_d   = in_addr_q;
    w_addr_d    = w_addr_q;
    b_addr_d    = b_addr_q;
    acc_d       = acc_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    pred_d      = pred_q;

    // Addresses always run one cycle ahead of the data consumed in MAC.
    // w_addr just walks the row-major weight array, so it is never reloaded mid-run.
    case (state_q)
      IDLE: begin
        in_addr_d = '0;
        w_addr_d  = '0;
        b_addr_d  = '0;
        if (bus.start) begin
          j_d     = '0;
          state_d = FETCH_BIAS;
        end
      end
      FETCH_BIAS: begin
        k_d       = '0;
        in_addr_d = in_addr_q + 1'b1;
        w_addr_d  = w_addr_q + 1'b1;
        state_d   = MAC;
      end
      MAC: begin
        acc_d     = ((k_q == '0) ? b_ext : acc_q) + prod;
        in_addr_d = in_addr_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = WRITE;
        end else begin
          k_d      = k_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      WRITE: begin
        out_data_d  = r;
        out_index_d = j_q;
        out_valid_d = 1'b1;
        if ((j_q == '0) || (r > best_val_q)) begin
          best_val_d = r;
          best_idx_d = j_q;
        end
        in_addr_d = '0;
        if (j_q == J_LAST) begin
          w_addr_d = '0;
          b_addr_d = '0;
          state_d  = DONE;
        end else begin
          j_d      = j_q + 1'b1;
          b_addr_d = j_q + 1'b1;
          state_d  = FETCH_BIAS;
        end
      end
      DONE: begin
        pred_d  = best_idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      k_q         <= '0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      acc_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      pred_q      <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
      acc_q       <= acc_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      pred_q      <= pred_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.in_addr         = in_addr_q;
  assign bus.w_addr          = w_addr_q;
  assign bus.b_addr          = b_addr_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_index       = out_index_q;
  assign bus.out_data        = out_data_q;
  assign bus.predicted_class = pred_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for a 4-input, 3-neuron layer: one sequencer without ReLU and
// one with ReLU, each fed by its own 1-cycle-latency memory models.
module tb_mlp_layer_sequencer;
  localparam logic [31:0] ONE    = 32'h0100_0000;
  localparam logic [31:0] TWO    = 32'h0200_0000;
  localparam logic [31:0] HALF   = 32'h0080_0000;
  localparam logic [31:0] NEG1   = 32'hFF00_0000;
  localparam logic [31:0] P127   = 32'h7F00_0000;
  localparam logic [31:0] N127   = 32'h8100_0000;
  localparam logic [31:0] SATP   = 32'h7FFF_FFFF;
  localparam logic [31:0] SATN   = 32'h8000_0000;
  localparam int          NVEC   = 7;

  typedef struct {
    string       name;
    bit          relu;
    logic [31:0] x[4];
    logic [31:0] w[12];
    logic [31:0] b[3];
    logic [31:0] exp_out[3];
    logic [1:0]  exp_class;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
  } cap_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[NVEC];

  logic [31:0] x_mem0[4], w_mem0[16], b_mem0[4];
  logic [31:0] x_mem1[4], w_mem1[16], b_mem1[4];
  cap_t caps0[$], caps1[$];
  int   done_cnt0, done_cnt1;

  mlp_layer_sequencer_if #(.INPUTS(4), .OUTPUTS(3), .DATA_W(32)) bus0 ();
  mlp_layer_sequencer_if #(.INPUTS(4), .OUTPUTS(3), .DATA_W(32)) bus1 ();

  mlp_layer_sequencer #(.INPUTS(4), .OUTPUTS(3), .DATA_W(32), .FRAC(24), .RELU(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  mlp_layer_sequencer #(.INPUTS(4), .OUTPUTS(3), .DATA_W(32), .FRAC(24), .RELU(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: data appears the cycle after the address.
  always @(posedge clk) begin
    bus0.in_data <= x_mem0[bus0.in_addr];
    bus0.w_data  <= w_mem0[bus0.w_addr];
    bus0.b_data  <= b_mem0[bus0.b_addr];
    bus1.in_data <= x_mem1[bus1.in_addr];
    bus1.w_data  <= w_mem1[bus1.w_addr];
    bus1.b_data  <= b_mem1[bus1.b_addr];
  end

  // Result stream and done pulses are logged on the falling edge.
  always @(negedge clk) begin
    if (bus0.out_valid) caps0.push_back('{data: bus0.out_data, idx: bus0.out_index});
    if (bus1.out_valid) caps1.push_back('{data: bus1.out_data, idx: bus1.out_index});
    if (bus0.done) done_cnt0 = done_cnt0 + 1;
    if (bus1.done) done_cnt1 = done_cnt1 + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic setStart(input int d, input bit v);
    if (d == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic loadMems(input int d, input int v);
    for (int i = 0; i < 16; i++) begin
      if (d == 0) w_mem0[i] = (i < 12) ? vecs[v].w[i] : 32'h0;
      else        w_mem1[i] = (i < 12) ? vecs[v].w[i] : 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      if (d == 0) begin
        x_mem0[i] = vecs[v].x[i];
        b_mem0[i] = (i < 3) ? vecs[v].b[i] : 32'h0;
      end else begin
        x_mem1[i] = vecs[v].x[i];
        b_mem1[i] = (i < 3) ? vecs[v].b[i] : 32'h0;
      end
    end
  endtask

  // Start is sampled in cycle 0; loop index n is the cycle number after that.
  task automatic applyStimulus(input int d, input int pa, input int pb, output int dc);
    logic dn;
    dc = -1;
    @(negedge clk);
    setStart(d, 1'b1);
    @(negedge clk);
    for (int n = 1; n <= 100; n++) begin
      setStart(d, (n == pa) || (n == pb));
      if (n == 1) checkOutput("busy_after_start", 64'(d == 0 ? bus0.busy : bus1.busy), 64'd1);
      dn = (d == 0) ? bus0.done : bus1.done;
      if (dn) begin
        dc = n;
        break;
      end
      @(negedge clk);
    end
    setStart(d, 1'b0);
  endtask

  task automatic runVector(input int v, input int pa, input int pb);
    int   d, dc, base, dbase, got, gotd;
    cap_t c;
    string nm;
    d  = vecs[v].relu ? 1 : 0;
    nm = vecs[v].name;
    loadMems(d, v);
    base  = (d == 0) ? caps0.size() : caps1.size();
    dbase = (d == 0) ? done_cnt0 : done_cnt1;
    applyStimulus(d, pa, pb, dc);
    repeat (3) @(negedge clk);
    got  = ((d == 0) ? caps0.size() : caps1.size()) - base;
    gotd = ((d == 0) ? done_cnt0 : done_cnt1) - dbase;
    checkOutput({nm, "_done_cycle"}, 64'(dc), 64'd19);
    checkOutput({nm, "_done_pulses"}, 64'(gotd), 64'd1);
    checkOutput({nm, "_valid_count"}, 64'(got), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got) c = (d == 0) ? caps0[base + i] : caps1[base + i];
      else         c = '{data: 32'hDEAD_BEEF, idx: 2'd3};
      checkOutput($sformatf("%s_index%0d", nm, i), 64'(c.idx), 64'(i));
      checkOutput($sformatf("%s_data%0d", nm, i), 64'(c.data), 64'(vecs[v].exp_out[i]));
    end
    checkOutput({nm, "_class"}, 64'(d == 0 ? bus0.predicted_class : bus1.predicted_class),
                64'(vecs[v].exp_class));
    checkOutput({nm, "_idle_busy"}, 64'(d == 0 ? bus0.busy : bus1.busy), 64'd0);
  endtask

  initial begin
    int base, dbase, first, second, dummy;
    checks = 0;
    errors = 0;
    done_cnt0 = 0;
    done_cnt1 = 0;
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;

    vecs[0] = '{name: "basic", relu: 1'b0, x: '{ONE, TWO, NEG1, HALF},
                w: '{ONE, 0, 0, 0, 0, ONE, 0, 0, 0, 0, NEG1, 0}, b: '{0, HALF, NEG1},
                exp_out: '{32'h0100_0000, 32'h0280_0000, 32'h0}, exp_class: 2'd1};
    vecs[1] = '{name: "saturate", relu: 1'b0, x: '{P127, P127, P127, P127},
                w: '{N127, N127, N127, N127, P127, P127, P127, P127, 0, 0, 0, 0}, b: '{0, 0, 0},
                exp_out: '{SATN, SATP, 32'h0}, exp_class: 2'd1};
    vecs[2] = '{name: "all_zero", relu: 1'b0, x: '{ONE, TWO, NEG1, HALF},
                w: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, b: '{0, 0, 0},
                exp_out: '{32'h0, 32'h0, 32'h0}, exp_class: 2'd0};
    vecs[3] = '{name: "tie", relu: 1'b0, x: '{ONE, 0, 0, 0},
                w: '{0, 0, 0, 0, ONE, 0, 0, 0, ONE, 0, 0, 0}, b: '{0, 0, 0},
                exp_out: '{32'h0, ONE, ONE}, exp_class: 2'd1};
    vecs[4] = '{name: "relu", relu: 1'b1, x: '{ONE, TWO, NEG1, HALF},
                w: '{ONE, 0, 0, 0, 0, ONE, 0, 0, 0, 0, NEG1, 0}, b: '{0, 32'hFB00_0000, NEG1},
                exp_out: '{ONE, 32'h0, 32'h0}, exp_class: 2'd0};
    vecs[5] = '{name: "floor", relu: 1'b0, x: '{32'hFFFF_FFFF, 32'h0000_0003, 0, 0},
                w: '{32'h1, 0, 0, 0, 0, HALF, 0, 0, 0, 0, 0, 0}, b: '{0, 0, 0},
                exp_out: '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0}, exp_class: 2'd1};
    vecs[6] = '{name: "wide_acc", relu: 1'b0, x: '{P127, P127, P127, P127},
                w: '{ONE, ONE, NEG1, NEG1, 0, 0, 0, 0, 0, 0, 0, 0},
                b: '{32'h0040_0000, 0, 32'hFFC0_0000},
                exp_out: '{32'h0040_0000, 32'h0, 32'hFFC0_0000}, exp_class: 2'd0};

    for (int i = 0; i < 16; i++) begin
      w_mem0[i] = 32'h0;
      w_mem1[i] = 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      x_mem0[i] = 32'h0; b_mem0[i] = 32'h0;
      x_mem1[i] = 32'h0; b_mem1[i] = 32'h0;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(bus0.busy), 64'd0);
    checkOutput("rst_done", 64'(bus0.done), 64'd0);
    checkOutput("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("rst_out_index", 64'(bus0.out_index), 64'd0);
    checkOutput("rst_out_data", 64'(bus0.out_data), 64'd0);
    checkOutput("rst_class", 64'(bus0.predicted_class), 64'd0);
    checkOutput("rst_in_addr", 64'(bus0.in_addr), 64'd0);
    checkOutput("rst_w_addr", 64'(bus0.w_addr), 64'd0);
    checkOutput("rst_b_addr", 64'(bus0.b_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      runVector(v, 0, 0);
    end

    $display("[TB] start pulses during a run");
    runVector(0, 5, 10);

    $display("[TB] reset in the middle of a run");
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(bus0.busy), 64'd0);
    checkOutput("midrst_done", 64'(bus0.done), 64'd0);
    checkOutput("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("midrst_out_data", 64'(bus0.out_data), 64'd0);
    checkOutput("midrst_class", 64'(bus0.predicted_class), 64'd0);
    #1;
    base  = caps0.size();
    dbase = done_cnt0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_valid", 64'(caps0.size() - base), 64'd0);
    checkOutput("midrst_no_done", 64'(done_cnt0 - dbase), 64'd0);
    runVector(0, 0, 0);

    $display("[TB] start held high re-triggers");
    loadMems(0, 0);
    first  = -1;
    second = -1;
    @(negedge clk);
    bus0.start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus0.done) begin
        if (first < 0) first = n;
        else begin
          second = n;
          break;
        end
      end
    end
    bus0.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held_first_done", 64'(first), 64'd19);
    checkOutput("held_second_done", 64'(second), 64'd39);
    checkOutput("held_class", 64'(bus0.predicted_class), 64'd1);
    checkOutput("held_idle_busy", 64'(bus0.busy), 64'd0);
    dummy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
Time-multiplexed controller for one fully-connected MLP layer. It uses a single shared multiply-accumulate path for all neurons. For each output neuron it streams input activations and weights from external synchronous memories, adds a bias, and writes out one Q7.24 result. It also tracks the argmax across neurons, producing the same predicted_class as the combinational network at a fraction of the area.

Parameters:
INPUTS, 784, input vector length (activations per neuron)
OUTPUTS, 10, neurons in the layer
DATA_W, 32, signed fixed-point word width (Q7.24)
FRAC, 24, fractional bits
RELU, 0, 1 = clamp negative results to 0 before output/argmax

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  begin layer evaluation; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse, layer complete
in_addr  out  $clog2(INPUTS)  input activation memory address
in_data  in  DATA_W  activation, valid 1 cycle after in_addr
w_addr  out  $clog2(INPUTS*OUTPUTS)  weight address, row-major (j*INPUTS+k)
w_data  in  DATA_W  weight, valid 1 cycle after w_addr
b_addr  out  $clog2(OUTPUTS)  bias address
b_data  in  DATA_W  bias, valid 1 cycle after b_addr
out_valid  out  1  one-cycle pulse, out_data/out_index valid
out_index  out  $clog2(OUTPUTS)  neuron index of out_data
out_data  out  DATA_W  neuron result, Q7.24
predicted_class  out  $clog2(OUTPUTS)  argmax of last completed layer

Behaviour:
- Reset: state IDLE. busy, done, out_valid, out_index, out_data, predicted_class, and all addresses are 0.
- FSM states: IDLE, FETCH_BIAS, MAC, WRITE, DONE.
- IDLE: addresses 0. If start=1, load j=0 and go to FETCH_BIAS.
- FETCH_BIAS (1 cycle): drive b_addr=j, in_addr=0, w_addr=j*INPUTS. Set k=0, go to MAC.
- MAC (INPUTS cycles, k=0..INPUTS-1): consume in_data/w_data for index k.
  - Product p = 64-bit signed (x*w) >>> FRAC (arithmetic shift, floor).
  - k=0: acc <= sext(b_data) + p. Otherwise acc <= acc + p.
  - acc is 64-bit signed with no internal saturation.
  - Drive addresses for k+1. At k=INPUTS-1 go to WRITE; the addresses driven in that cycle are don't-care.
- WRITE (1 cycle):
  - r = sat(acc) to [0x80000000, 0x7FFFFFFF]. If RELU=1 and r<0, r=0.
  - Register out_data=r and out_index=j. out_valid is high in the following cycle.
  - Argmax: for j=0, best_val=r and best_idx=0. Otherwise update only if r > best_val (strict), so ties keep the lower index.
  - If j==OUTPUTS-1 go to DONE, else j++ and go to FETCH_BIAS.
- DONE (1 cycle): predicted_class <= best_idx, done=1, then IDLE. predicted_class holds until the next DONE.
- Latency: done is high exactly OUTPUTS*(INPUTS+2)+1 cycles after the cycle start was sampled (7861 at defaults). Per neuron: INPUTS+2 cycles.
- Outputs are registered. out_valid pulses exactly OUTPUTS times per run, in index order 0..OUTPUTS-1.
- start while busy is ignored, with no restart or queueing. start held high continuously re-triggers on the cycle after DONE (IDLE accepts it).
- rst mid-run: next cycle is IDLE with reset values. No done or out_valid follows, and the partial argmax is discarded (predicted_class = 0).
- Memories are assumed to have fixed 1-cycle read latency with no stall handshake.

Test Plan:
1. INPUTS=4, OUTPUTS=3, RELU=0; x=[1.0,2.0,-1.0,0.5]; b=[0,0.5,-1.0]; W rows [1,0,0,0],[0,1,0,0],[0,0,-1,0] -> out_data 0x01000000, 0x02800000, 0x00000000 at indices 0,1,2; predicted_class=1; done at cycle 19 after start.
2. Saturation: INPUTS=4, all x=w=127.0 -> out_data 0x7FFFFFFF. Same with w=-127.0 -> 0x80000000; argmax picks the saturated-positive neuron.
3. Ties: all weights/biases 0 -> every out_data 0, predicted_class=0. Then make rows 1 and 2 equal at 1.0 -> predicted_class=1.
4. RELU=1: case-1 vectors with bias[1]=-5.0 -> out_data[1]=0, others unchanged; predicted_class=0 (tie at 1.0 vs 0 → index 0 is max).
5. Control: start pulsed in cycles 5 and 10 of a run is ignored (done still at 19). rst asserted at cycle 7 -> busy=0 next cycle, no out_valid/done; fresh start reproduces the case-1 results.
6. Defaults (784x10) with the MNIST sample vector and trained weights -> all 10 out_data match the combinational mlp_neural_net bit-exactly; done at cycle 7861; predicted_class equal.
